// File: rtl/cmp_search_ctrl.sv
// Binary-search reader for the RGB magnitude comparator: recovers the comparator's b operand.
// Optional consistency checking (flag decode + range check, err output) under CMP_SEARCH_CHECK_EN.
module cmp_search_ctrl #(
   parameter int W = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   output logic [W-1:0]              guess,
   input  logic                      red_i,
   input  logic                      green_i,
   input  logic                      blue_i,
   output logic                      busy,
   output logic                      done,
   output logic [W-1:0]              result,
   output logic [$clog2(W+2)-1:0]    probes,
   output logic                      err
);

   localparam int PW = $clog2(W+2);
   localparam logic [W:0]    R_ONE   = (W+1)'(1);
   localparam logic [W:0]    R_MAX   = {1'b0, {W{1'b1}}};
   localparam logic [PW-1:0] P_ONE   = PW'(1);
   localparam logic [PW-1:0] P_LAST  = PW'(W);

   typedef enum logic [1:0] {S_IDLE, S_CHECK, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [W:0]      lo_q, lo_d, hi_q, hi_d;
   logic [W-1:0]    guess_q, guess_d, result_q, result_d;
   logic [PW-1:0]   probes_q, probes_d;
   logic            busy_q, busy_d, done_q, done_d, err_q, err_d;

   logic [W:0]      guess_ext, hi_gt, lo_lt;

   // Low W bits of (a+b)>>1, with the sum held in W+1 bits.
   function automatic logic [W-1:0] midpoint(input logic [W:0] a, input logic [W:0] b);
      logic [W:0] s;
      s = a + b;
      return s[W:1];
   endfunction

`ifndef CMP_SEARCH_CHECK_EN
   logic unused_green;
   assign unused_green = green_i;
`endif

   always_comb begin
      state_d   = state_q;
      lo_d      = lo_q;
      hi_d      = hi_q;
      guess_d   = guess_q;
      result_d  = result_q;
      probes_d  = probes_q;
      busy_d    = busy_q;
      done_d    = done_q;
      err_d     = err_q;
      guess_ext = {1'b0, guess_q};
      hi_gt     = guess_ext - R_ONE;
      lo_lt     = guess_ext + R_ONE;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               lo_d     = '0;
               hi_d     = R_MAX;
               guess_d  = R_MAX[W:1];
               probes_d = '0;
               result_d = '0;
               done_d   = 1'b0;
               err_d    = 1'b0;
               busy_d   = 1'b1;
               state_d  = S_CHECK;
            end
         end
         S_CHECK: begin
            probes_d = probes_q + P_ONE;
`ifdef CMP_SEARCH_CHECK_EN
            // Range check is done before the update so no wrapped value is ever compared.
            if (red_i && green_i && !blue_i) begin
               result_d = guess_q;
               done_d   = 1'b1;
               busy_d   = 1'b0;
               state_d  = S_DONE;
            end else if (red_i && !green_i && blue_i && (lo_q < guess_ext)) begin
               hi_d    = hi_gt;
               guess_d = midpoint(lo_q, hi_gt);
            end else if (!red_i && green_i && blue_i && (guess_ext < hi_q)) begin
               lo_d    = lo_lt;
               guess_d = midpoint(lo_lt, hi_q);
            end else begin
               result_d = '0;
               err_d    = 1'b1;
               done_d   = 1'b1;
               busy_d   = 1'b0;
               state_d  = S_DONE;
            end
`else
            // Probe cap guarantees termination even on nonsense flags.
            if (!blue_i || (probes_q == P_LAST)) begin
               result_d = guess_q;
               done_d   = 1'b1;
               busy_d   = 1'b0;
               state_d  = S_DONE;
            end else if (red_i) begin
               hi_d    = hi_gt;
               guess_d = midpoint(lo_q, hi_gt);
            end else begin
               lo_d    = lo_lt;
               guess_d = midpoint(lo_lt, hi_q);
            end
`endif
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         lo_q     <= '0;
         hi_q     <= '0;
         guess_q  <= '0;
         result_q <= '0;
         probes_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         lo_q     <= lo_d;
         hi_q     <= hi_d;
         guess_q  <= guess_d;
         result_q <= result_d;
         probes_q <= probes_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   assign guess  = guess_q;
   assign result = result_q;
   assign probes = probes_q;
   assign busy   = busy_q;
   assign done   = done_q;
   assign err    = err_q;

endmodule
